bus_stream_fifo: RTL and testbench

- Memory-mapped bus responder on the SoC peripheral bus.
- The CPU pushes 32-bit words through bus writes; a hardware consumer drains them through a valid/ready stream port.
- Intended as the CPU-to-hardware feed path for peripherals such as audio or SD bulk transfers.
- Sits behind the address decoder like other peripherals, with its own select ANDed into i_request.

---
 rtl/bus_stream_fifo.sv | 143 ++++++++++++++
 tb/tb_bus_stream_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_stream_fifo.sv
// CPU-to-hardware word FIFO: the bus side pushes through a DATA register, and a
// show-ahead valid/ready stream port drains it. STATUS and CONTROL (flush) registers are also provided.
module bus_stream_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     mem [DEPTH];

  logic            full;
  logic            empty;
  logic            pop;
  logic [1:0]      reg_sel;
  logic            data_write;
  logic            push;
  logic            stall;
  logic            flush;
  logic [31:0]     status_word;

  // Only address bits [3:2] select a register.
  logic            unused_addr;
  assign unused_addr = ^{i_address[31:4], i_address[1:0]};

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign pop         = !empty && i_ready;
  assign reg_sel     = i_address[3:2];
  assign data_write  = (state_q == S_EXEC) && i_rw && (reg_sel == REG_DATA);
  assign push        = data_write && !full;
  assign stall       = data_write && full;
  assign flush       = (state_q == S_EXEC) && i_rw && (reg_sel == REG_CONTROL) && i_wdata[0];
  assign status_word = {16'h0000, 8'(count_q), 6'b000000, full, empty};

  // Bus handshake: IDLE -> EXEC (access happens once) -> ACK until request drops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_request) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          state_d = S_ACK;
          ready_d = 1'b1;
          rdata_d = (!i_rw && reg_sel == REG_STATUS) ? status_word : 32'h0;
        end
      end
      S_ACK: begin
        if (!i_request) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Flush wins over a same-cycle pop; a push and a pop together leave count unchanged.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; valid data is tracked by count and pointers.
  always_ff @(posedge i_clock) begin
    if (push && !i_reset) mem[wr_ptr_q] <= i_wdata;
  end

  assign o_ready = ready_q;
  assign o_rdata = rdata_q;
  assign o_data  = mem[rd_ptr_q];
  assign o_valid = !empty;

endmodule

// File: tb/tb_bus_stream_fifo.sv
// Directed bench for bus_stream_fifo: a register-access vector table plus
// hand-written sequences for drain, full stall, held request, flush and reset.
module tb_bus_stream_fifo;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_DATA    = 32'h0;
  localparam logic [31:0] A_STATUS  = 32'h4;
  localparam logic [31:0] A_CONTROL = 32'h8;
  localparam logic [31:0] A_RSVD    = 32'hC;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  bus_stream_fifo #(.DEPTH(16)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_request (i_request),
    .i_rw      (i_rw),
    .i_address (i_address),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at a negedge; drives one full request/acknowledge and returns rdata and latency.
  task automatic bus_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
    i_request = 1'b1;
    i_rw      = rw;
    i_address = addr;
    i_wdata   = wdata;
    lat       = 0;
    do begin
      @(negedge i_clock);
      lat++;
    end while (!o_ready && lat < 60);
    rdata     = o_rdata;
    i_request = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    int          lat;
    bus_access(1'b1, addr, wdata, rd, lat);
    if (lat >= 60) check("write_timeout", 32'(lat), 32'd2);
  endtask

  task automatic status_is(input string name, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    bus_access(1'b0, A_STATUS, 32'h0, rd, lat);
    check(name, rd, exp);
  endtask

  // With i_ready held high, checks the current head and lets it pop on the next edge.
  task automatic expect_pop(input string name, input logic [31:0] exp);
    check({name, "_valid"}, 32'(o_valid), 32'd1);
    check({name, "_data"}, o_data, exp);
    @(negedge i_clock);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 60) begin
      @(negedge i_clock);
      n++;
    end
    check(name, 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;

    vecs[0]  = '{1'b0, A_STATUS,  32'h0,        32'h0000_0001};
    vecs[1]  = '{1'b1, A_DATA,    32'h0000_000A, 32'h0};
    vecs[2]  = '{1'b1, A_DATA,    32'h0000_000B, 32'h0};
    vecs[3]  = '{1'b1, A_DATA,    32'h0000_000C, 32'h0};
    vecs[4]  = '{1'b0, A_STATUS,  32'h0,        32'h0000_0300};
    vecs[5]  = '{1'b0, A_DATA,    32'h0,        32'h0};
    vecs[6]  = '{1'b0, A_CONTROL, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, A_RSVD,    32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, A_RSVD,    32'h0,        32'h0};
    vecs[9]  = '{1'b1, A_CONTROL, 32'h0000_0002, 32'h0};
    vecs[10] = '{1'b0, A_STATUS,  32'h0,        32'h0000_0300};

    i_reset   = 1'b1;
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_address = 32'h0;
    i_wdata   = 32'h0;
    i_ready   = 1'b0;
    repeat (3) @(negedge i_clock);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_rdata", o_rdata, 32'h0);
    i_reset = 1'b0;
    @(negedge i_clock);

    // Register map and handshake latency; bit0-clear CONTROL write must not flush.
    for (int i = 0; i < 11; i++) begin
      bus_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    i_ready = 1'b1;
    expect_pop("drain0", 32'hA);
    expect_pop("drain1", 32'hB);
    expect_pop("drain2", 32'hC);
    check("drain_empty", 32'(o_valid), 32'd0);
    i_ready = 1'b0;

    // Full FIFO: 17th write stalls until a single pop frees a slot.
    for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'h100 + 32'(i));
    status_is("full_status", 32'h0000_1002);
    i_request = 1'b1;
    i_rw      = 1'b1;
    i_address = A_DATA;
    i_wdata   = 32'h11;
    repeat (5) @(negedge i_clock);
    check("stall_ready_low", 32'(o_ready), 32'd0);
    i_ready = 1'b1;
    @(negedge i_clock);
    i_ready = 1'b0;
    check("stall_pop_ready_low", 32'(o_ready), 32'd0);
    @(negedge i_clock);
    check("stall_release", 32'(o_ready), 32'd1);
    i_request = 1'b0;
    @(negedge i_clock);
    status_is("after_stall_status", 32'h0000_1002);
    i_ready = 1'b1;
    for (int i = 1; i < 16; i++) expect_pop($sformatf("full_pop%0d", i), 32'h100 + 32'(i));
    expect_pop("full_last", 32'h11);
    check("full_drained", 32'(o_valid), 32'd0);
    i_ready = 1'b0;

    // A request held in ACK for 10 cycles pushes once.
    i_request = 1'b1;
    i_rw      = 1'b1;
    i_address = A_DATA;
    i_wdata   = 32'h55;
    wait_ready("hold_ready");
    repeat (10) @(negedge i_clock);
    check("hold_still_ready", 32'(o_ready), 32'd1);
    i_request = 1'b0;
    @(negedge i_clock);
    status_is("hold_status", 32'h0000_0100);

    // Flush with the consumer ready.
    for (int i = 0; i < 4; i++) bus_write(A_DATA, 32'h200 + 32'(i));
    status_is("pre_flush_status", 32'h0000_0500);
    i_ready = 1'b1;
    bus_write(A_CONTROL, 32'h1);
    check("flush_valid", 32'(o_valid), 32'd0);
    status_is("flush_status", 32'h0000_0001);
    i_ready = 1'b0;
    bus_write(A_DATA, 32'h77);
    check("post_flush_valid", 32'(o_valid), 32'd1);
    check("post_flush_data", o_data, 32'h77);
    i_ready = 1'b1;
    @(negedge i_clock);
    i_ready = 1'b0;
    check("post_flush_empty", 32'(o_valid), 32'd0);

    // Reset during a stalled full write; the held request then executes once.
    for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'h300 + 32'(i));
    i_request = 1'b1;
    i_rw      = 1'b1;
    i_address = A_DATA;
    i_wdata   = 32'h99;
    repeat (3) @(negedge i_clock);
    check("pre_reset_stall", 32'(o_ready), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clock);
    check("mid_reset_ready", 32'(o_ready), 32'd0);
    check("mid_reset_valid", 32'(o_valid), 32'd0);
    i_reset = 1'b0;
    lat = 0;
    do begin
      @(negedge i_clock);
      lat++;
    end while (!o_ready && lat < 60);
    check("reset_reexec_latency", 32'(lat), 32'd2);
    i_request = 1'b0;
    @(negedge i_clock);
    status_is("reset_reexec_status", 32'h0000_0100);
    check("reset_reexec_data", o_data, 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
